// File: rtl/deu_ibuf_pkg.sv
// Shared widths and default sizing for the DEU instruction buffer.
package deu_ibuf_pkg;
  localparam int LA64_PC_WIDTH   = 64;
  localparam int LA64_INST_WIDTH = 32;
  localparam int IB_DEPTH        = 8;
  localparam int IB_FW           = 2;
  localparam int IB_DW           = 2;
endpackage

// File: rtl/deu_lead_ones.sv
// Counts the run of ones starting at bit 0; a zero ends the run.
module deu_lead_ones #(
  parameter int N = 2
) (
  input  logic [N-1:0]             vec,
  output logic [$clog2(N+1)-1:0]   cnt
);
  localparam int CW = $clog2(N+1);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int k = 0; k < N; k++) begin
      run = run & vec[k];
      cnt = cnt + CW'(run);
    end
  end
endmodule

// File: rtl/deu_ibuf.sv
// Circular instruction buffer between IFU fetch and DEU decode:
// FW in-order writes per cycle, oldest DW entries presented to decode.
module deu_ibuf
  import deu_ibuf_pkg::*;
#(
  parameter int  DEPTH = IB_DEPTH,
  parameter int  FW    = IB_FW,
  parameter int  DW    = IB_DW,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [FW-1:0]                 ifu_valid,
  input  logic [FW*LA64_PC_WIDTH-1:0]   ifu_pc,
  input  logic [FW*LA64_INST_WIDTH-1:0] ifu_inst,
  output logic                          ifu_ready,
  output logic [DW-1:0]                 deu_val,
  output logic [DW*LA64_PC_WIDTH-1:0]   deu_pc,
  output logic [DW*LA64_INST_WIDTH-1:0] deu_inst,
  input  logic [DW-1:0]                 deu_decode,
  output logic [CNT_W-1:0]              ib_count
);
  localparam int PC_W   = LA64_PC_WIDTH;
  localparam int INST_W = LA64_INST_WIDTH;
  localparam int EN_W   = $clog2(FW+1);
  localparam int DQ_W   = $clog2(DW+1);

  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];

  logic [EN_W-1:0]   enq_n, enq_cnt;
  logic [DQ_W-1:0]   deq_n;
  logic [DW-1:0]     deq_req;
  logic              do_enq;
  logic [DEPTH-1:0]  wr_en;
  logic [PC_W-1:0]   wr_pc   [DEPTH];
  logic [INST_W-1:0] wr_inst [DEPTH];

  deu_lead_ones #(.N(FW)) u_enq_ones (.vec(ifu_valid), .cnt(enq_n));
  deu_lead_ones #(.N(DW)) u_deq_ones (.vec(deq_req),   .cnt(deq_n));

  // Readiness depends only on the registered count, never on this cycle's decode.
  assign ifu_ready = (CNT_W'(DEPTH) - count_reg) >= CNT_W'(FW);
  assign do_enq    = ifu_ready & ~flush;
  assign enq_cnt   = do_enq ? enq_n : '0;
  assign deq_req   = deu_decode & deu_val;
  assign ib_count  = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_out
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx      = head_reg + PTR_W'(gi);
      assign deu_val[gi] = count_reg > CNT_W'(gi);
      assign deu_pc[gi*PC_W +: PC_W]       = deu_val[gi] ? pc_q[rd_idx]   : '0;
      assign deu_inst[gi*INST_W +: INST_W] = deu_val[gi] ? inst_q[rd_idx] : '0;
    end

    // Each entry works out which fetch slot (if any) lands on it this cycle.
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr
      logic [PTR_W-1:0]  ofs;
      logic [PC_W-1:0]   sel_pc;
      logic [INST_W-1:0] sel_inst;
      assign ofs       = PTR_W'(gi) - tail_reg;
      assign wr_en[gi] = CNT_W'(ofs) < CNT_W'(enq_cnt);
      always_comb begin
        sel_pc   = '0;
        sel_inst = '0;
        for (int k = 0; k < FW; k++) begin
          if (ofs == PTR_W'(k)) begin
            sel_pc   = ifu_pc[k*PC_W +: PC_W];
            sel_inst = ifu_inst[k*INST_W +: INST_W];
          end
        end
      end
      assign wr_pc[gi]   = sel_pc;
      assign wr_inst[gi] = sel_inst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) begin
        pc_q[e]   <= wr_pc[e];
        inst_q[e] <= wr_inst[e];
      end
    end
  end

  always_comb begin
    head_next  = head_reg + PTR_W'(deq_n);
    tail_next  = tail_reg + PTR_W'(enq_cnt);
    count_next = count_reg + CNT_W'(enq_cnt) - CNT_W'(deq_n);
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  a_valid_contig: assert property (@(posedge clk) disable iff (!rst_n)
    (ifu_valid & FW'(ifu_valid + FW'(1))) == '0);
  a_decode_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (deu_decode & ~deu_val) == '0);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_reg <= CNT_W'(DEPTH));
endmodule
